processing_element: RTL and testbench

Single-issue RV32I execution tile of the CGRA fabric. Takes one instruction and its PC from the array controller and requests operand values from an external shared register file. It executes the instruction, performs at most one word memory access, and returns a write-back request plus the next PC. The design has no internal register file and no fetch logic.

---
 rtl/processing_element_pkg.sv | 40 ++++
 rtl/pe_alu.sv | 28 ++
 rtl/processing_element.sv | 187 ++++++++++++++++++
 tb/tb_processing_element.sv | 180 ++++++++++++++++++
 4 files changed

// File: rtl/processing_element_pkg.sv
// processing_element_pkg: RV32I encodings, FSM states and ALU operations for the CGRA processing element
package processing_element_pkg;
    localparam logic [6:0] OP_R     = 7'b0110011;
    localparam logic [6:0] OP_I     = 7'b0010011;
    localparam logic [6:0] OP_LUI   = 7'b0110111;
    localparam logic [6:0] OP_AUIPC = 7'b0010111;
    localparam logic [6:0] OP_JAL   = 7'b1101111;
    localparam logic [6:0] OP_JALR  = 7'b1100111;
    localparam logic [6:0] OP_BR    = 7'b1100011;
    localparam logic [6:0] OP_LOAD  = 7'b0000011;
    localparam logic [6:0] OP_STORE = 7'b0100011;
    localparam logic [2:0] F3_ADD   = 3'b000;
    localparam logic [2:0] F3_SLL   = 3'b001;
    localparam logic [2:0] F3_WORD  = 3'b010;
    localparam logic [2:0] F3_SR    = 3'b101;
    localparam logic [6:0] F7_BASE  = 7'b0000000;
    localparam logic [6:0] F7_ALT   = 7'b0100000;
    localparam logic [6:0] F7_MUL   = 7'b0000001;

    typedef enum logic [2:0] {S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB} state_e;

    typedef enum logic [3:0] {
        ALU_ADD, ALU_SUB, ALU_SLL, ALU_SLT, ALU_SLTU, ALU_XOR,
        ALU_SRL, ALU_SRA, ALU_OR, ALU_AND, ALU_MUL, ALU_PASSB
    } alu_op_e;

    // alt selects SUB/SRA (funct7 = 0100000)
    function automatic alu_op_e alu_of(input logic [2:0] f3, input logic alt);
        case (f3)
            3'b000:  return alt ? ALU_SUB : ALU_ADD;
            3'b001:  return ALU_SLL;
            3'b010:  return ALU_SLT;
            3'b011:  return ALU_SLTU;
            3'b100:  return ALU_XOR;
            3'b101:  return alt ? ALU_SRA : ALU_SRL;
            3'b110:  return ALU_OR;
            default: return ALU_AND;
        endcase
    endfunction
endpackage

// File: rtl/pe_alu.sv
// pe_alu: combinational RV32I ALU; defining PE_MUL_EN adds the RV32M MUL low word
module pe_alu
    import processing_element_pkg::*;
(
    input  alu_op_e     i_op,
    input  logic [31:0] i_a,
    input  logic [31:0] i_b,
    output logic [31:0] o_y
);
    always_comb begin
        case (i_op)
            ALU_SUB:   o_y = i_a - i_b;
            ALU_SLL:   o_y = i_a << i_b[4:0];
            ALU_SLT:   o_y = {31'd0, $signed(i_a) < $signed(i_b)};
            ALU_SLTU:  o_y = {31'd0, i_a < i_b};
            ALU_XOR:   o_y = i_a ^ i_b;
            ALU_SRL:   o_y = i_a >> i_b[4:0];
            ALU_SRA:   o_y = $unsigned($signed(i_a) >>> i_b[4:0]);
            ALU_OR:    o_y = i_a | i_b;
            ALU_AND:   o_y = i_a & i_b;
            ALU_PASSB: o_y = i_b;
`ifdef PE_MUL_EN
            ALU_MUL:   o_y = i_a * i_b;
`endif
            default:   o_y = i_a + i_b;
        endcase
    end
endmodule

// File: rtl/processing_element.sv
// processing_element: single-issue RV32I execution tile, FETCH/DECODE/EXEC/MEM/WB with external register file
// PE_MUL_EN enables RV32M MUL; otherwise that encoding executes as a NOP.
module processing_element
    import processing_element_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] PCin,
    input  logic [31:0] instruction,
    input  logic        mem_ack,
    input  logic        data_Ready,
    input  logic [31:0] AmuxIn,
    input  logic [31:0] BmuxIn,
    output logic [31:0] mem_address,
    output logic        reg_select,
    output logic        mem_read,
    output logic [31:0] messReg,
    output logic [4:0]  rs1Out,
    output logic [4:0]  rs2Out,
    output logic [4:0]  rdOut,
    output logic        rdWrite,
    output logic        mem_write,
    output logic [31:0] result_out,
    output logic [31:0] PCout
);
`ifdef PE_MUL_EN
    localparam logic MUL_EN = 1'b1;
`else
    localparam logic MUL_EN = 1'b0;
`endif

    state_e      r_state;
    logic [31:0] r_pc, r_instr, r_a, r_b;

    logic [6:0]  w_opc, w_f7;
    logic [2:0]  w_f3;
    logic [4:0]  w_rd;
    logic [31:0] w_imm_i, w_imm_s, w_imm_b, w_imm_u, w_imm_j;
    logic        w_alt, w_mul, w_r_ok, w_i_ok, w_br_ok, w_taken, w_cmp;
    logic        w_dest, w_mem, w_store;
    alu_op_e     w_op;
    logic [31:0] w_opa, w_opb, w_y, w_next;

    assign w_opc   = r_instr[6:0];
    assign w_rd    = r_instr[11:7];
    assign w_f3    = r_instr[14:12];
    assign w_f7    = r_instr[31:25];
    assign w_imm_i = {{20{r_instr[31]}}, r_instr[31:20]};
    assign w_imm_s = {{20{r_instr[31]}}, r_instr[31:25], r_instr[11:7]};
    assign w_imm_b = {{19{r_instr[31]}}, r_instr[31], r_instr[7], r_instr[30:25], r_instr[11:8], 1'b0};
    assign w_imm_u = {r_instr[31:12], 12'd0};
    assign w_imm_j = {{11{r_instr[31]}}, r_instr[31], r_instr[19:12], r_instr[20], r_instr[30:21], 1'b0};
    assign w_alt   = w_f7 == F7_ALT;
    assign w_mul   = MUL_EN && w_f7 == F7_MUL && w_f3 == F3_ADD;
    assign w_r_ok  = w_f7 == F7_BASE || (w_alt && (w_f3 == F3_ADD || w_f3 == F3_SR));
    assign w_i_ok  = w_f3 == F3_SLL ? w_f7 == F7_BASE : w_f3 == F3_SR ? (w_f7 == F7_BASE || w_alt) : 1'b1;
    // funct3[2] picks the ordered compare, [1] unsigned, [0] inverts
    assign w_br_ok = w_f3[2:1] != 2'b01;
    assign w_cmp   = w_f3[2] ? (w_f3[1] ? r_a < r_b : $signed(r_a) < $signed(r_b)) : r_a == r_b;
    assign w_taken = w_cmp ^ w_f3[0];
    assign w_store = w_opc == OP_STORE;

    always_comb begin
        w_op   = ALU_ADD;
        w_opa  = r_a;
        w_opb  = r_b;
        w_dest = 1'b0;
        w_mem  = 1'b0;
        w_next = r_pc + 32'd4;
        case (w_opc)
            OP_R: begin
                w_op   = w_mul ? ALU_MUL : alu_of(w_f3, w_alt);
                w_dest = w_r_ok || w_mul;
            end
            OP_I: begin
                w_op   = alu_of(w_f3, w_alt && w_f3 == F3_SR);
                w_opb  = w_imm_i;
                w_dest = w_i_ok;
            end
            OP_LUI: begin
                w_op   = ALU_PASSB;
                w_opb  = w_imm_u;
                w_dest = 1'b1;
            end
            OP_AUIPC: begin
                w_opa  = r_pc;
                w_opb  = w_imm_u;
                w_dest = 1'b1;
            end
            OP_JAL: begin
                w_opa  = r_pc;
                w_opb  = 32'd4;
                w_dest = 1'b1;
                w_next = r_pc + w_imm_j;
            end
            OP_JALR: begin
                w_opa  = r_pc;
                w_opb  = 32'd4;
                w_dest = w_f3 == F3_ADD;
                w_next = w_f3 == F3_ADD ? (r_a + w_imm_i) & ~32'd1 : r_pc + 32'd4;
            end
            OP_BR: w_next = w_br_ok && w_taken ? r_pc + w_imm_b : r_pc + 32'd4;
            OP_LOAD: begin
                w_opb  = w_imm_i;
                w_mem  = w_f3 == F3_WORD;
                w_dest = w_f3 == F3_WORD;
            end
            OP_STORE: begin
                w_opb  = w_imm_s;
                w_mem  = w_f3 == F3_WORD;
            end
            default: ;
        endcase
    end

    pe_alu u_alu (
        .i_op (w_op),
        .i_a  (w_opa),
        .i_b  (w_opb),
        .o_y  (w_y)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= S_FETCH;
            r_pc        <= '0;
            r_instr     <= '0;
            r_a         <= '0;
            r_b         <= '0;
            mem_address <= '0;
            reg_select  <= 1'b0;
            mem_read    <= 1'b0;
            mem_write   <= 1'b0;
            messReg     <= '0;
            rs1Out      <= '0;
            rs2Out      <= '0;
            rdOut       <= '0;
            rdWrite     <= 1'b0;
            result_out  <= '0;
            PCout       <= '0;
        end else begin
            case (r_state)
                S_FETCH: begin
                    r_pc       <= PCin;
                    r_instr    <= instruction;
                    rs1Out     <= instruction[19:15];
                    rs2Out     <= instruction[24:20];
                    reg_select <= 1'b1;
                    r_state    <= S_DECODE;
                end
                S_DECODE: if (data_Ready) begin
                    r_a        <= AmuxIn;
                    r_b        <= BmuxIn;
                    reg_select <= 1'b0;
                    r_state    <= S_EXEC;
                end
                S_EXEC: if (w_mem) begin
                    mem_address <= w_y;
                    mem_read    <= !w_store;
                    mem_write   <= w_store;
                    messReg     <= w_store ? r_b : messReg;
                    r_state     <= S_MEM;
                end else begin
                    result_out <= w_y;
                    rdOut      <= w_rd;
                    rdWrite    <= w_dest && w_rd != 5'd0;
                    PCout      <= w_next;
                    r_state    <= S_WB;
                end
                S_MEM: if (mem_ack) begin
                    mem_read   <= 1'b0;
                    mem_write  <= 1'b0;
                    result_out <= w_dest ? BmuxIn : w_y;
                    rdOut      <= w_rd;
                    rdWrite    <= w_dest && w_rd != 5'd0;
                    PCout      <= w_next;
                    r_state    <= S_WB;
                end
                S_WB: begin
                    rdWrite <= 1'b0;
                    r_state <= S_FETCH;
                end
                default: r_state <= S_FETCH;
            endcase
        end
    end
endmodule

// File: tb/tb_processing_element.sv
// tb_processing_element: scoreboard bench for processing_element (MUL expectation follows PE_MUL_EN)
module tb_processing_element;
    logic        clk = 1'b0, rst_n = 1'b0;
    logic [31:0] PCin = '0, instruction = '0, AmuxIn = '0, BmuxIn = '0;
    logic        mem_ack = 1'b0, data_Ready = 1'b0;
    logic [31:0] mem_address, messReg, result_out, PCout;
    logic        reg_select, mem_read, mem_write, rdWrite;
    logic [4:0]  rs1Out, rs2Out, rdOut;

    typedef struct {
        logic [31:0] pc, instr, a, b, ld;
        int          dr_wait, ack_wait;
        logic [4:0]  rs1, rs2, rd;
        logic [31:0] res, npc;
        logic        wr, chk;
        logic [1:0]  mem;
        logic [31:0] addr, sdata;
    } txn_t;

    txn_t        sb_q[$];
    txn_t        t;
    int          n_chk = 0, n_err = 0;
    logic [31:0] last_pc = '0;

    always #5 clk = ~clk;

    processing_element dut (
        .clk(clk), .rst_n(rst_n), .PCin(PCin), .instruction(instruction),
        .mem_ack(mem_ack), .data_Ready(data_Ready), .AmuxIn(AmuxIn), .BmuxIn(BmuxIn),
        .mem_address(mem_address), .reg_select(reg_select), .mem_read(mem_read),
        .messReg(messReg), .rs1Out(rs1Out), .rs2Out(rs2Out), .rdOut(rdOut),
        .rdWrite(rdWrite), .mem_write(mem_write), .result_out(result_out), .PCout(PCout)
    );

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // drives one instruction from FETCH; expectations travel through the scoreboard queue
    task automatic run(input string tag, input txn_t s);
        txn_t e;
        sb_q.push_back(s);
        PCin = s.pc; instruction = s.instr; AmuxIn = s.a; BmuxIn = s.b;
        data_Ready = s.dr_wait == 0; mem_ack = 1'b0;
        tick;
        e = sb_q.pop_front();
        check({tag, " rs"}, {rs1Out, rs2Out}, {e.rs1, e.rs2});
        for (int i = 0; i < s.dr_wait; i++) begin
            check({tag, " stall"}, {reg_select, rdWrite, mem_read, mem_write}, 4'b1000);
            check({tag, " stall_pc"}, PCout, last_pc);
            tick;
        end
        check({tag, " req"}, reg_select, 1);
        data_Ready = 1'b1;
        tick;
        data_Ready = 1'b0; AmuxIn = 32'hA5A5A5A5; BmuxIn = 32'h5A5A5A5A;
        check({tag, " req_off"}, reg_select, 0);
        tick;
        if (e.mem != 2'd0) begin
            for (int i = 0; i <= s.ack_wait; i++) begin
                check({tag, " strobe"}, {mem_read, mem_write}, e.mem == 2'd1 ? 2'b10 : 2'b01);
                check({tag, " addr"}, mem_address, e.addr);
                if (e.mem == 2'd2) check({tag, " sdata"}, messReg, e.sdata);
                if (i == s.ack_wait) begin BmuxIn = s.ld; mem_ack = 1'b1; end
                tick;
            end
            mem_ack = 1'b0; BmuxIn = 32'h5A5A5A5A;
        end
        check({tag, " nomem"}, {mem_read, mem_write}, 0);
        check({tag, " wr"}, rdWrite, e.wr);
        check({tag, " pc"}, PCout, e.npc);
        if (e.chk) begin
            check({tag, " rd"}, rdOut, e.rd);
            check({tag, " res"}, result_out, e.res);
        end
        last_pc = e.npc;
        tick;
        check({tag, " pulse"}, rdWrite, 0);
        check({tag, " pc_hold"}, PCout, e.npc);
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: bench did not reach its summary");
        $fatal(1);
    end

    initial begin
        instruction = 32'h002081B3; data_Ready = 1'b1; mem_ack = 1'b1; AmuxIn = 32'h11; BmuxIn = 32'h22;
        tick; tick;
        check("rst addr", mem_address, 0);
        check("rst sdata", messReg, 0);
        check("rst res", result_out, 0);
        check("rst pc", PCout, 0);
        check("rst ctl", {reg_select, mem_read, mem_write, rdWrite, rs1Out, rs2Out, rdOut}, 0);
        data_Ready = 1'b0; mem_ack = 1'b0;
        rst_n = 1'b1;
        tick;
        check("rst leave_fetch", reg_select, 1);
        rst_n = 1'b0;
        #1;
        check("rst async", reg_select, 0);
        tick;
        rst_n = 1'b1;

        t = '{32'h1, 32'h00000013, 32'd2, 32'd3, 32'd0, 0, 0, 5'd0, 5'd0, 5'd0, 32'd2, 32'd5, 1'b0, 1'b1, 2'd0, 32'd0, 32'd0};
        run("nop", t);
        t = '{32'h10, 32'h002081B3, 32'd2, 32'd3, 32'd0, 0, 0, 5'd1, 5'd2, 5'd3, 32'd5, 32'h14, 1'b1, 1'b1, 2'd0, 32'd0, 32'd0};
        run("add", t);
        t = '{32'h14, 32'h40208233, 32'd2, 32'd3, 32'd0, 0, 0, 5'd1, 5'd2, 5'd4, 32'hFFFFFFFF, 32'h18, 1'b1, 1'b1, 2'd0, 32'd0, 32'd0};
        run("sub", t);
        t = '{32'h18, 32'h4020D333, 32'h80000000, 32'h24, 32'd0, 0, 0, 5'd1, 5'd2, 5'd6, 32'hF8000000, 32'h1C, 1'b1, 1'b1, 2'd0, 32'd0, 32'd0};
        run("sra", t);
        t = '{32'h1C, 32'h0020B3B3, 32'd1, 32'hFFFFFFFF, 32'd0, 0, 0, 5'd1, 5'd2, 5'd7, 32'd1, 32'h20, 1'b1, 1'b1, 2'd0, 32'd0, 32'd0};
        run("sltu", t);
        t = '{32'h20, 32'h0020A433, 32'd1, 32'hFFFFFFFF, 32'd0, 0, 0, 5'd1, 5'd2, 5'd8, 32'd0, 32'h24, 1'b1, 1'b1, 2'd0, 32'd0, 32'd0};
        run("slt", t);
        t = '{32'h24, 32'hFFF0C493, 32'h0F0F0F0F, 32'd0, 32'd0, 0, 0, 5'd1, 5'd31, 5'd9, 32'hF0F0F0F0, 32'h28, 1'b1, 1'b1, 2'd0, 32'd0, 32'd0};
        run("xori", t);
        t = '{32'h28, 32'h0040D513, 32'h80000000, 32'd0, 32'd0, 0, 0, 5'd1, 5'd4, 5'd10, 32'h08000000, 32'h2C, 1'b1, 1'b1, 2'd0, 32'd0, 32'd0};
        run("srli", t);
        t = '{32'h2C, 32'h4040D513, 32'h80000000, 32'd0, 32'd0, 0, 0, 5'd1, 5'd4, 5'd10, 32'hF8000000, 32'h30, 1'b1, 1'b1, 2'd0, 32'd0, 32'd0};
        run("srai", t);
        t = '{32'h30, 32'h123455B7, 32'd0, 32'd0, 32'd0, 0, 0, 5'd8, 5'd3, 5'd11, 32'h12345000, 32'h34, 1'b1, 1'b1, 2'd0, 32'd0, 32'd0};
        run("lui", t);
        t = '{32'h100, 32'h00001617, 32'd0, 32'd0, 32'd0, 0, 0, 5'd0, 5'd0, 5'd12, 32'h1100, 32'h104, 1'b1, 1'b1, 2'd0, 32'd0, 32'd0};
        run("auipc", t);
        t = '{32'h200, 32'h008000EF, 32'd0, 32'd0, 32'd0, 0, 0, 5'd0, 5'd8, 5'd1, 32'h204, 32'h208, 1'b1, 1'b1, 2'd0, 32'd0, 32'd0};
        run("jal", t);
        t = '{32'h300, 32'h005100E7, 32'h1000, 32'd0, 32'd0, 0, 0, 5'd2, 5'd5, 5'd1, 32'h304, 32'h1004, 1'b1, 1'b1, 2'd0, 32'd0, 32'd0};
        run("jalr", t);
        t = '{32'h400, 32'h0080A283, 32'h100, 32'd0, 32'hDEADBEEF, 0, 3, 5'd1, 5'd8, 5'd5, 32'hDEADBEEF, 32'h404, 1'b1, 1'b1, 2'd1, 32'h108, 32'd0};
        run("lw", t);
        t = '{32'h404, 32'h0020A623, 32'h200, 32'hCAFE, 32'd0, 0, 1, 5'd1, 5'd2, 5'd0, 32'd0, 32'h408, 1'b0, 1'b0, 2'd2, 32'h20C, 32'hCAFE};
        run("sw", t);
        t = '{32'h40, 32'h00208863, 32'd7, 32'd7, 32'd0, 0, 0, 5'd1, 5'd2, 5'd0, 32'd0, 32'h50, 1'b0, 1'b0, 2'd0, 32'd0, 32'd0};
        run("beq_t", t);
        t = '{32'h40, 32'h00208863, 32'd7, 32'd8, 32'd0, 0, 0, 5'd1, 5'd2, 5'd0, 32'd0, 32'h44, 1'b0, 1'b0, 2'd0, 32'd0, 32'd0};
        run("beq_n", t);
        t = '{32'h40, 32'h0020C863, 32'hFFFFFFFF, 32'd1, 32'd0, 0, 0, 5'd1, 5'd2, 5'd0, 32'd0, 32'h50, 1'b0, 1'b0, 2'd0, 32'd0, 32'd0};
        run("blt", t);
        t = '{32'h40, 32'h0020E863, 32'hFFFFFFFF, 32'd1, 32'd0, 0, 0, 5'd1, 5'd2, 5'd0, 32'd0, 32'h44, 1'b0, 1'b0, 2'd0, 32'd0, 32'd0};
        run("bltu", t);
        t = '{32'h500, 32'h00008283, 32'h100, 32'd0, 32'd0, 0, 0, 5'd1, 5'd0, 5'd0, 32'd0, 32'h504, 1'b0, 1'b0, 2'd0, 32'd0, 32'd0};
        run("lb_illegal", t);
`ifdef PE_MUL_EN
        t = '{32'h508, 32'h022081B3, 32'd6, 32'd7, 32'd0, 0, 0, 5'd1, 5'd2, 5'd3, 32'd42, 32'h50C, 1'b1, 1'b1, 2'd0, 32'd0, 32'd0};
`else
        t = '{32'h508, 32'h022081B3, 32'd6, 32'd7, 32'd0, 0, 0, 5'd1, 5'd2, 5'd3, 32'd0, 32'h50C, 1'b0, 1'b0, 2'd0, 32'd0, 32'd0};
`endif
        run("mul", t);
        t = '{32'h600, 32'h002081B3, 32'd10, 32'd20, 32'd0, 5, 0, 5'd1, 5'd2, 5'd3, 32'd30, 32'h604, 1'b1, 1'b1, 2'd0, 32'd0, 32'd0};
        run("stall", t);

        // abort a load while its read strobe is up
        PCin = 32'h700; instruction = 32'h0080A283; AmuxIn = 32'h100; data_Ready = 1'b1;
        tick; tick; tick;
        check("abort strobe", mem_read, 1);
        rst_n = 1'b0;
        #1;
        check("abort clear", {mem_read, mem_write, rdWrite, reg_select}, 0);
        tick;
        rst_n = 1'b1; data_Ready = 1'b0; mem_ack = 1'b1;
        for (int i = 0; i < 6; i++) begin
            tick;
            check("abort quiet", {mem_read, mem_write, rdWrite}, 0);
        end
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
